// File: rtl/qam_demodulator.sv
// qam_demodulator: mixes N parallel received samples against cos/sin carriers
// and integrates SYM_WORDS valid words per symbol, dumping one saturated I/Q
// pair per symbol boundary.
//
// Handshake: there is no backpressure. A word is consumed on any rising clk
// edge where din_valid is high. sym_start only matters when din_valid is high.
// out_valid is a one-cycle pulse. i_out, q_out and sat are valid while it is
// high, and they hold their values between pulses.
module qam_demodulator #(
  parameter int N         = 16,
  parameter int SYM_WORDS = 4,
  parameter int SHIFT     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din_valid,
  input  logic                sym_start,
  input  logic [16*N-1:0]     din,
  input  logic [16*N-1:0]     cos,
  input  logic [16*N-1:0]     sin,
  output logic signed [15:0]  i_out,
  output logic signed [15:0]  q_out,
  output logic                out_valid,
  output logic                sat,
  output logic                align_err
);

  localparam int LS_W  = 16 + $clog2(N);
  localparam int CNT_W = $clog2(SYM_WORDS);
  localparam int ACC_W = LS_W + CNT_W;
  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(SYM_WORDS - 1);
  localparam logic signed [ACC_W-1:0] MAX_V    = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MIN_V    = ACC_W'(-32768);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Word-tracking FSM state
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               align_err_q, align_err_d;
  logic               v0, f0, l0;
  logic [CNT_W-1:0]   idx0;

  // Pipeline tags: valid / first word / last word
  logic               v1_q, f1_q, l1_q;
  logic               v2_q, f2_q, l2_q;
  logic               dump3_q;

  // Datapath registers
  logic signed [15:0]       pc_d [N];
  logic signed [15:0]       ps_d [N];
  logic signed [15:0]       pc_q [N];
  logic signed [15:0]       ps_q [N];
  logic signed [LS_W-1:0]   si_d, sq_d, si_q, sq_q;
  logic signed [ACC_W-1:0]  acc_i_d, acc_q_d, acc_i_q, acc_q_q;
  logic signed [15:0]       i_out_d, q_out_d, i_out_q, q_out_q;
  logic                     sat_d, sat_q, out_valid_q;
  logic [16:0]              res_i, res_q;

  // Shift, then clip to 16 bits. The result is {clipped, value}.
  function automatic logic [16:0] sat16(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (s > MAX_V)      return {1'b1, 16'h7fff};
    else if (s < MIN_V) return {1'b1, 16'h8000};
    else                return {1'b0, s[15:0]};
  endfunction

  // Classify the incoming word: accepted, first or last. Also find the next word index.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    align_err_d = align_err_q;
    v0          = 1'b0;
    f0          = 1'b0;
    l0          = 1'b0;
    idx0        = '0;
    if (din_valid) begin
      if (state_q == S_IDLE) begin
        if (sym_start) begin
          v0 = 1'b1;
          f0 = 1'b1;
        end
      end else begin
        v0 = 1'b1;
        // A restart in mid-symbol throws away the partial symbol.
        if (sym_start && (cnt_q != '0)) align_err_d = 1'b1;
        if (sym_start || (cnt_q == '0)) f0 = 1'b1;
        else                            idx0 = cnt_q;
      end
      if (v0) begin
        l0      = (idx0 == LAST_IDX);
        cnt_d   = idx0 + 1'b1;
        state_d = S_RUN;
      end
    end
  end

  // FSM, counter and sticky error register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      align_err_q <= align_err_d;
    end
  end

  // Stage 1: per-lane products. din lane i pairs with carrier lane N-1-i.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      logic signed [15:0] d_l, c_l, s_l;
      logic signed [31:0] prod_c, prod_s;
      d_l       = din[16*i +: 16];
      c_l       = cos[16*(N-1-i) +: 16];
      s_l       = sin[16*(N-1-i) +: 16];
      prod_c    = 32'(d_l) * 32'(c_l);
      prod_s    = 32'(d_l) * 32'(s_l);
      pc_d[i]   = prod_c[31:16];
      ps_d[i]   = prod_s[31:16];
    end
  end

  // Stage 2: lane sums. The quadrature sum is negated.
  always_comb begin
    logic signed [LS_W-1:0] sum_c, sum_s;
    sum_c = '0;
    sum_s = '0;
    for (int i = 0; i < N; i++) begin
      sum_c = sum_c + LS_W'(pc_q[i]);
      sum_s = sum_s + LS_W'(ps_q[i]);
    end
    si_d = sum_c;
    sq_d = -sum_s;
  end

  // Stage 3: accumulate. Word 0 reloads, which also discards an aborted partial.
  always_comb begin
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    if (v2_q) begin
      acc_i_d = f2_q ? ACC_W'(si_q) : acc_i_q + ACC_W'(si_q);
      acc_q_d = f2_q ? ACC_W'(sq_q) : acc_q_q + ACC_W'(sq_q);
    end
  end

  // Stage 4: saturate the finished accumulator when the dump tag arrives.
  always_comb begin
    res_i   = sat16(acc_i_q);
    res_q   = sat16(acc_q_q);
    i_out_d = i_out_q;
    q_out_d = q_out_q;
    sat_d   = sat_q;
    if (dump3_q) begin
      i_out_d = res_i[15:0];
      q_out_d = res_q[15:0];
      sat_d   = res_i[16] | res_q[16];
    end
  end

  // Pipeline registers and tags. Reset clears every in-flight tag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v1_q        <= 1'b0;
      f1_q        <= 1'b0;
      l1_q        <= 1'b0;
      v2_q        <= 1'b0;
      f2_q        <= 1'b0;
      l2_q        <= 1'b0;
      dump3_q     <= 1'b0;
      si_q        <= '0;
      sq_q        <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        pc_q[i] <= '0;
        ps_q[i] <= '0;
      end
    end else begin
      v1_q        <= v0;
      f1_q        <= f0;
      l1_q        <= l0;
      pc_q        <= pc_d;
      ps_q        <= ps_d;
      v2_q        <= v1_q;
      f2_q        <= f1_q;
      l2_q        <= l1_q;
      si_q        <= si_d;
      sq_q        <= sq_d;
      dump3_q     <= v2_q & l2_q;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      sat_q       <= sat_d;
      out_valid_q <= dump3_q;
    end
  end

  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_qam_demodulator.sv
// tb_qam_demodulator: directed bench for qam_demodulator (N=4, SYM_WORDS=4).
// dut_a uses SHIFT=2. dut_b uses SHIFT=0 for the saturation vectors.
module tb_qam_demodulator;

  localparam int N = 4;
  localparam int W = 16 * N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         din_valid = 1'b0;
  logic         sym_start = 1'b0;
  logic         b_en      = 1'b0;
  logic [W-1:0] din       = '0;
  logic [W-1:0] car_cos   = '0;
  logic [W-1:0] car_sin   = '0;

  logic signed [15:0] i_a, q_a, i_b, q_b;
  logic ov_a, sat_a, ae_a, ov_b, sat_b, ae_b;
  logic din_valid_b;
  assign din_valid_b = din_valid & b_en;

  qam_demodulator #(.N(N), .SYM_WORDS(4), .SHIFT(2)) dut_a (
    .clk(clk), .reset(reset), .din_valid(din_valid), .sym_start(sym_start),
    .din(din), .cos(car_cos), .sin(car_sin),
    .i_out(i_a), .q_out(q_a), .out_valid(ov_a), .sat(sat_a), .align_err(ae_a)
  );

  qam_demodulator #(.N(N), .SYM_WORDS(4), .SHIFT(0)) dut_b (
    .clk(clk), .reset(reset), .din_valid(din_valid_b), .sym_start(sym_start),
    .din(din), .cos(car_cos), .sin(car_sin),
    .i_out(i_b), .q_out(q_b), .out_valid(ov_b), .sat(sat_b), .align_err(ae_b)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_a_q[$];
  logic [32:0] exp_b_q[$];
  int          cyc_a_q[$];
  int          cyc_b_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [32:0] mk(input logic s, input int i, input int q);
    return {s, 16'(i), 16'(q)};
  endfunction

  function automatic logic [W-1:0] rep(input logic [15:0] x);
    return {N{x}};
  endfunction

  // Monitor: pop and compare on every out_valid pulse
  always @(negedge clk) begin
    if (ov_a) begin
      if (exp_a_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected_out: got i=%0d q=%0d expected no output", i_a, q_a);
      end else begin
        chk("a_result", {31'd0, sat_a, i_a, q_a}, {31'd0, exp_a_q.pop_front()});
        chk("a_latency", 64'(cyc), 64'(cyc_a_q.pop_front()));
      end
    end
    if (ov_b) begin
      if (exp_b_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_out: got i=%0d q=%0d expected no output", i_b, q_b);
      end else begin
        chk("b_result", {31'd0, sat_b, i_b, q_b}, {31'd0, exp_b_q.pop_front()});
        chk("b_latency", 64'(cyc), 64'(cyc_b_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic ss, input logic [W-1:0] d,
                       input logic [W-1:0] c, input logic [W-1:0] s);
    din_valid = v;
    sym_start = ss;
    din       = d;
    car_cos   = c;
    car_sin   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  // One four-word symbol. The result is expected 4 cycles after the last word.
  // Gap words are invalid, carry random data and assert sym_start.
  task automatic send_sym(input logic [W-1:0] d, input logic [W-1:0] c,
                          input logic [W-1:0] s, input logic ss_first,
                          input logic gaps, input logic be,
                          input logic [32:0] ea, input logic [32:0] eb);
    b_en = be;
    for (int w = 0; w < 4; w++) begin
      if (gaps && w > 0)
        drive(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      if (w == 3) begin
        exp_a_q.push_back(ea);
        cyc_a_q.push_back(cyc + 4);
        if (be) begin
          exp_b_q.push_back(eb);
          cyc_b_q.push_back(cyc + 4);
        end
      end
      drive(1'b1, ss_first && (w == 0), d, c, s);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_a", 64'(i_a), 64'd0);
    chk("rst_q_a", 64'(q_a), 64'd0);
    chk("rst_ov_a", 64'(ov_a), 64'd0);
    chk("rst_sat_a", 64'(sat_a), 64'd0);
    chk("rst_ae_a", 64'(ae_a), 64'd0);
    chk("rst_i_b", 64'(i_b), 64'd0);

    // Release reset with word 0 presented in the same cycle.
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic in-phase: 4 lanes * 4096 * 4 words >>> 2
    send_sym(rep(16'd16384), rep(16'd16384), '0, 1'b1, 1'b0, 1'b0,
             mk(1'b0, 16384, 0), '0);
    idle(2);

    // Quadrature with gaps: the Q sum is negated
    send_sym(rep(16'd16384), '0, rep(16'd16384), 1'b1, 1'b1, 1'b0,
             mk(1'b0, 0, -16384), '0);
    idle(6);
    @(negedge clk);
    chk("hold_i_a", {48'd0, i_a}, 64'h0);
    chk("hold_q_a", {48'd0, q_a}, 64'hc000);

    // Saturation and sign: SHIFT=0 clips, SHIFT=2 does not
    send_sym(rep(16'd16384), rep(16'd16384), '0, 1'b1, 1'b0, 1'b1,
             mk(1'b0, 16384, 0), mk(1'b1, 32767, 0));
    send_sym(rep(16'hc000), rep(16'd16384), '0, 1'b1, 1'b0, 1'b1,
             mk(1'b0, -16384, 0), mk(1'b1, -32768, 0));
    idle(6);
    b_en = 1'b0;
    @(negedge clk);
    chk("ae_a_before_misalign", 64'(ae_a), 64'd0);

    // Back-to-back and lane order: din lane 0 pairs with cos lane 3
    for (int k = 0; k < 3; k++)
      send_sym({48'd0, 16'd16384}, {16'd16384, 48'd0}, '0, (k == 0), 1'b0, 1'b0,
               mk(1'b0, 4096, 0), '0);
    idle(6);

    // Misalignment: sym_start on word 2 aborts the symbol and restarts it
    drive(1'b1, 1'b1, rep(16'd16384), rep(16'd16384), '0);
    drive(1'b1, 1'b0, rep(16'd16384), rep(16'd16384), '0);
    send_sym(rep(16'd16384), rep(16'd8192), '0, 1'b1, 1'b0, 1'b0,
             mk(1'b0, 8192, 0), '0);
    idle(6);
    @(negedge clk);
    chk("ae_a_set", 64'(ae_a), 64'd1);
    send_sym(rep(16'd16384), rep(16'd16384), '0, 1'b1, 1'b0, 1'b0,
             mk(1'b0, 16384, 0), '0);
    idle(6);
    @(negedge clk);
    chk("ae_a_sticky", 64'(ae_a), 64'd1);
    chk("ae_b_clear", 64'(ae_b), 64'd0);

    // Reset mid-symbol: a single sampled low cycle
    drive(1'b1, 1'b1, rep(16'd16384), rep(16'd16384), '0);
    drive(1'b1, 1'b0, rep(16'd16384), rep(16'd16384), '0);
    reset     = 1'b0;
    din_valid = 1'b1;
    sym_start = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    din_valid = 1'b0;
    sym_start = 1'b0;
    @(negedge clk);
    chk("mid_rst_i_a", 64'(i_a), 64'd0);
    chk("mid_rst_sat_a", 64'(sat_a), 64'd0);
    chk("mid_rst_ae_a", 64'(ae_a), 64'd0);
    chk("mid_rst_ov_a", 64'(ov_a), 64'd0);
    chk("mid_rst_i_b", 64'(i_b), 64'd0);
    chk("mid_rst_sat_b", 64'(sat_b), 64'd0);

    // Words without sym_start are ignored after reset
    for (int k = 0; k < 4; k++)
      drive(1'b1, 1'b0, rep(16'd16384), rep(16'd16384), '0);
    idle(8);
    send_sym(rep(16'd16384), rep(16'd16384), '0, 1'b1, 1'b0, 1'b0,
             mk(1'b0, 16384, 0), '0);
    idle(8);

    @(negedge clk);
    chk("a_queue_empty", 64'(exp_a_q.size()), 64'd0);
    chk("b_queue_empty", 64'(exp_b_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qam_demodulator.md
# qam_demodulator

Receive-side counterpart of the parallel Fourier QAM modulator. Mixes N parallel 16-bit received samples per clock against the in-phase and quadrature carriers and integrates over one symbol of SYM_WORDS valid input words. At each symbol boundary it dumps one saturated 16-bit I/Q pair. It sits after the channel/ADC sample path and feeds the symbol slicer.

## Interface
- N, 16: parallel samples per clock word.
- SYM_WORDS, 4: valid input words per symbol; at least 2, power of two.
- SHIFT, 2: arithmetic right shift applied to the accumulator before saturation; range 0..ACC_W-16.
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- din_valid  input  1  din/cos/sin carry a valid word this cycle.
- sym_start  input  1  qualified by din_valid; marks the current word as word 0 of a symbol.
- din  input  16*N  received samples, lane i = din[16i+15:16i], signed Q15.
- cos  input  16*N  in-phase carrier, signed Q15.
- sin  input  16*N  quadrature carrier, signed Q15.
- i_out  output  16  demodulated in-phase symbol, signed.
- q_out  output  16  demodulated quadrature symbol, signed.
- out_valid  output  1  one-cycle pulse; i_out/q_out/sat are valid.
- sat  output  1  i_out or q_out clipped for this symbol; valid with out_valid.
- align_err  output  1  sticky; set when a symbol is aborted.

## Operation
- Lane pairing matches the modulator: din lane i multiplies cos/sin lane N-1-i.
- Per lane: pc_i = (din_i*cos_{N-1-i}) >>> 16; ps_i = (din_i*sin_{N-1-i}) >>> 16.
  - Full 32-bit signed product, arithmetic shift, truncation toward minus infinity.
  - Result is 16 bits.
- Lane sums: SI = sum pc_i; SQ = -(sum ps_i). Width 16+clog2(N), sign-extended, no wrap.
- Accumulators are ACC_W = 16+clog2(N)+clog2(SYM_WORDS) bits signed. Cannot overflow.
- Output: (acc >>> SHIFT), saturated to [-32768, 32767]. sat = 1 if either channel clipped.
- FSM states:
  - IDLE: ignore words until din_valid && sym_start. That word is word 0; go to RUN.
  - RUN: each valid word increments the word counter (0..SYM_WORDS-1). On word SYM_WORDS-1, dump.
- After a dump, the next valid word is word 0 of the following symbol. Sym_start on it is optional and is not an error. Stay in RUN.
- Sym_start with counter != 0 in RUN:
  - Discard the partial symbol; no out_valid for it.
  - Set align_err.
  - Restart with the current word as word 0.
- din_valid low: accumulators, counter, and FSM hold. Invalid words never contribute.

## Timing
- Pipeline stages:
  1. Registered products.
  2. Registered lane sums.
  3. Accumulate/dump.
  4. Registered saturated output.
- A "valid/first/last" tag travels with each word through the pipeline.
- Latency: the last word of a symbol accepted at cycle t gives out_valid high at t+4 for exactly one cycle.
- Back-to-back symbols need no bubble. In the dump cycle, the accumulator loads word 0 of the next symbol if present.
- Full throughput: one word per clock, sustained indefinitely.
- i_out, q_out, and sat hold their last values between out_valid pulses.
- Reset (reset=0), synchronous, wins over every other input:
  - i_out=0, q_out=0, out_valid=0, sat=0, align_err=0.
  - FSM to IDLE, counter=0, accumulators=0, all pipeline tags cleared.
  - Reset mid-symbol: no out_valid for any in-flight word.
- First word accepted after reset release: the cycle reset is sampled high, if din_valid && sym_start.

## Test plan
Bench parameters: N=4, SYM_WORDS=4, SHIFT=2.
- Basic in-phase: din=16384, cos=16384, sin=0 in all lanes; sym_start on word 0; 4 consecutive valid words. Required: out_valid 4 cycles after word 3, i_out=16384, q_out=0, sat=0.
- Quadrature, with gaps: cos=0, sin=16384, din=16384; din_valid toggles 1,0,1,0... Required: q_out=-16384, i_out=0. Result is independent of gaps; out_valid 4 cycles after the 4th valid word.
- Saturation and sign: rebuild with SHIFT=0; din=16384, cos=16384, sin=0. Required: i_out=32767, sat=1. Then din=-16384 gives i_out=-32768, sat=1.
- Back-to-back and lane order: 3 symbols with no gaps, sym_start only on the first word. Set cos lanes to {0,0,0,16384} (lane 3 = 16384) and din lanes to {16384,0,0,0} (lane 0). Required: 3 out_valid pulses spaced 4 cycles apart, each i_out=4096.
- Misalignment: sym_start asserted on word 2 of a symbol. Required: that symbol produces no output, align_err=1 and sticky, next full symbol is output correctly.
- Reset mid-symbol: reset low for 1 cycle after word 1. Required: all outputs 0 the next cycle, no out_valid, words ignored until a new sym_start.
